// File: rtl/ram_dp_clr_if.sv
// Port bundle for ram_dp_clr: the write, read and clear requests plus the read-data and status returns.
// Clock and reset are kept outside so one bundle can serve any clocking arrangement.
interface ram_dp_clr_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) ();
    logic              wren;
    logic [ADDR_W-1:0] wraddr;
    logic [DATA_W-1:0] data;
    logic              rden;
    logic [ADDR_W-1:0] rdaddr;
    logic              clr;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic              busy;

    modport master (
        output wren, wraddr, data, rden, rdaddr, clr,
        input  q, q_valid, busy
    );

    modport slave (
        input  wren, wraddr, data, rden, rdaddr, clr,
        output q, q_valid, busy
    );
endinterface

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with a registered read, a selectable read-during-write policy,
// and a clear engine that zeroes every word after reset or on request.
module ram_dp_clr #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 5,
    parameter int RDW_MODE = 0
) (
    input  logic         clock,
    input  logic         resetn,
    ram_dp_clr_if.slave  bus
);
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [DATA_W-1:0] q_reg, q_next;
    logic              q_valid_reg, q_valid_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_clear;
    logic              wr_fire;
    logic              rd_fire;
    logic              bypass;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_clear = (state_reg == ST_CLEAR);

    // A clear request in IDLE swallows any access presented in the same cycle.
    assign wr_fire = !in_clear && bus.wren && !bus.clr;
    assign rd_fire = !in_clear && bus.rden && !bus.clr;
    assign bypass  = (RDW_MODE != 0) && wr_fire && (bus.wraddr == bus.rdaddr);

    // The clear engine borrows the single write port while it runs.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wraddr;
        mem_wdata = bus.data;
        if (in_clear) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_reg;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (in_clear) begin
            if (bus.clr) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_IDLE;
                end
            end
        end else if (bus.clr) begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
        end
    end

    always_comb begin
        q_next       = q_reg;
        q_valid_next = 1'b0;
        if (rd_fire) begin
            q_valid_next = 1'b1;
            q_next       = bypass ? bus.data : mem[bus.rdaddr];
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_CLEAR;
            cnt_reg     <= '0;
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            q_reg       <= q_next;
            q_valid_reg <= q_valid_next;
        end
    end

    assign bus.q       = q_reg;
    assign bus.q_valid = q_valid_reg;
    assign bus.busy    = in_clear;
endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: read-first and write-first 32x4 instances share stimulus,
// plus an 8-bit x 8-word instance; all checked against an array model.
module tb_ram_dp_clr;
    logic clock    = 1'b0;
    logic resetn   = 1'b0;
    logic resetn_c = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    ram_dp_clr_if #(.DATA_W(4), .ADDR_W(5)) bus_a ();
    ram_dp_clr_if #(.DATA_W(4), .ADDR_W(5)) bus_b ();
    ram_dp_clr_if #(.DATA_W(8), .ADDR_W(3)) bus_c ();

    assign bus_b.wren   = bus_a.wren;
    assign bus_b.wraddr = bus_a.wraddr;
    assign bus_b.data   = bus_a.data;
    assign bus_b.rden   = bus_a.rden;
    assign bus_b.rdaddr = bus_a.rdaddr;
    assign bus_b.clr    = bus_a.clr;

    ram_dp_clr #(.DATA_W(4), .ADDR_W(5), .RDW_MODE(0)) dut_rf (.clock(clock), .resetn(resetn), .bus(bus_a));
    ram_dp_clr #(.DATA_W(4), .ADDR_W(5), .RDW_MODE(1)) dut_wf (.clock(clock), .resetn(resetn), .bus(bus_b));
    ram_dp_clr #(.DATA_W(8), .ADDR_W(3), .RDW_MODE(0)) dut_sm (.clock(clock), .resetn(resetn_c), .bus(bus_c));

    // Reference model: plain word array plus the expected output of each policy.
    logic [3:0] model_mem [32];
    logic [3:0] exp_q0, exp_q1;
    logic       exp_valid;

    task automatic model_zero();
        for (int i = 0; i < 32; i++) model_mem[i] = 4'h0;
    endtask

    task automatic model_access(input logic we, input logic [4:0] wa, input logic [3:0] d,
                                input logic re, input logic [4:0] ra);
        if (re) begin
            exp_q0 = model_mem[ra];
            exp_q1 = (we && wa == ra) ? d : model_mem[ra];
        end
        exp_valid = re;
        if (we) model_mem[wa] = d;
    endtask

    task automatic cycle_a(input logic we, input logic [4:0] wa, input logic [3:0] d,
                           input logic re, input logic [4:0] ra, input logic cl);
        bus_a.wren = we; bus_a.wraddr = wa; bus_a.data = d;
        bus_a.rden = re; bus_a.rdaddr = ra; bus_a.clr = cl;
        @(posedge clock); #1;
    endtask

    task automatic cycle_c(input logic we, input logic [2:0] wa, input logic [7:0] d,
                           input logic re, input logic [2:0] ra);
        bus_c.wren = we; bus_c.wraddr = wa; bus_c.data = d;
        bus_c.rden = re; bus_c.rdaddr = ra; bus_c.clr = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus_a.q !== 4'h0 || bus_a.q_valid !== 1'b0 || bus_a.busy !== 1'b1 || bus_b.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: q=%h q_valid=%b busy=%b/%b, required q=0 q_valid=0 busy=1",
                     bus_a.q, bus_a.q_valid, bus_a.busy, bus_b.busy);
        end
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            n++;
            if (!bus_a.busy) break;
        end
        checks++;
        if (n != 32 || bus_b.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_len: busy low after %0d edges (wf busy=%b), required 32", n, bus_b.busy);
        end
        $display("reset: busy dropped after %0d edges", n);
        model_zero();
        exp_q0 = 4'h0; exp_q1 = 4'h0; exp_valid = 1'b0;
    endtask

    task automatic test_defaults();
        for (int i = 0; i < 32; i++) begin
            cycle_a(1'b0, 5'd0, 4'h0, 1'b1, 5'(i), 1'b0);
            model_access(1'b0, 5'd0, 4'h0, 1'b1, 5'(i));
            checks++;
            if (bus_a.q !== exp_q0 || bus_b.q !== exp_q1 || bus_a.q_valid !== 1'b1 || bus_b.q_valid !== 1'b1) begin
                errors++;
                $display("FAIL default_read[%0d]: q=%h/%h valid=%b/%b, required q=0 valid=1",
                         i, bus_a.q, bus_b.q, bus_a.q_valid, bus_b.q_valid);
            end
        end
        cycle_a(1'b0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b0);
        checks++;
        if (bus_a.q_valid !== 1'b0 || bus_b.q_valid !== 1'b0) begin
            errors++;
            $display("FAIL default_valid_drop: q_valid=%b/%b, required 0", bus_a.q_valid, bus_b.q_valid);
        end
        $display("defaults: read all 32 addresses");
    endtask

    task automatic test_write_read();
        cycle_a(1'b1, 5'd5, 4'hA, 1'b0, 5'd0, 1'b0);  model_access(1'b1, 5'd5, 4'hA, 1'b0, 5'd0);
        cycle_a(1'b1, 5'd31, 4'h3, 1'b0, 5'd0, 1'b0); model_access(1'b1, 5'd31, 4'h3, 1'b0, 5'd0);
        cycle_a(1'b0, 5'd0, 4'h0, 1'b1, 5'd5, 1'b0);  model_access(1'b0, 5'd0, 4'h0, 1'b1, 5'd5);
        checks++;
        if (bus_a.q !== 4'hA || bus_b.q !== 4'hA || bus_a.q_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_addr5: q=%h/%h valid=%b, required A valid=1", bus_a.q, bus_b.q, bus_a.q_valid);
        end
        cycle_a(1'b0, 5'd0, 4'h0, 1'b1, 5'd31, 1'b0); model_access(1'b0, 5'd0, 4'h0, 1'b1, 5'd31);
        checks++;
        if (bus_a.q !== 4'h3 || bus_b.q !== 4'h3 || bus_b.q_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_addr31: q=%h/%h valid=%b, required 3 valid=1", bus_a.q, bus_b.q, bus_b.q_valid);
        end
        cycle_a(1'b1, 5'd31, 4'h8, 1'b0, 5'd0, 1'b0); model_access(1'b1, 5'd31, 4'h8, 1'b0, 5'd0);
        checks++;
        if (bus_a.q !== 4'h3 || bus_b.q !== 4'h3 || bus_a.q_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: q=%h/%h valid=%b, required 3 held valid=0", bus_a.q, bus_b.q, bus_a.q_valid);
        end
        $display("write_read: addr5=%h addr31=%h", 4'hA, 4'h3);
    endtask

    task automatic test_rdw();
        cycle_a(1'b1, 5'd7, 4'h2, 1'b0, 5'd0, 1'b0); model_access(1'b1, 5'd7, 4'h2, 1'b0, 5'd0);
        cycle_a(1'b1, 5'd7, 4'h9, 1'b1, 5'd7, 1'b0); model_access(1'b1, 5'd7, 4'h9, 1'b1, 5'd7);
        checks++;
        if (bus_a.q !== 4'h2 || bus_b.q !== 4'h9) begin
            errors++;
            $display("FAIL rdw_same_addr: q read-first=%h write-first=%h, required 2 and 9", bus_a.q, bus_b.q);
        end
        cycle_a(1'b0, 5'd0, 4'h0, 1'b1, 5'd7, 1'b0); model_access(1'b0, 5'd0, 4'h0, 1'b1, 5'd7);
        checks++;
        if (bus_a.q !== 4'h9 || bus_b.q !== 4'h9) begin
            errors++;
            $display("FAIL rdw_followup: q=%h/%h, required 9", bus_a.q, bus_b.q);
        end
        $display("rdw: read-first=%h write-first=%h", bus_a.q, bus_b.q);
    endtask

    task automatic test_random();
        logic we, re;
        logic [4:0] wa, ra;
        logic [3:0] d;
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            d  = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cycle_a(we, wa, d, re, ra, 1'b0);
            model_access(we, wa, d, re, ra);
            checks++;
            if (bus_a.q !== exp_q0 || bus_b.q !== exp_q1 ||
                bus_a.q_valid !== exp_valid || bus_b.q_valid !== exp_valid) begin
                errors++; bad++;
                $display("FAIL random[%0d]: q=%h/%h valid=%b/%b, required q=%h/%h valid=%b",
                         i, bus_a.q, bus_b.q, bus_a.q_valid, bus_b.q_valid, exp_q0, exp_q1, exp_valid);
            end
        end
        $display("random: 300 cycles, %0d bad", bad);
    endtask

    task automatic test_clear();
        int n;
        cycle_a(1'b1, 5'd3, 4'h5, 1'b0, 5'd0, 1'b0);  model_access(1'b1, 5'd3, 4'h5, 1'b0, 5'd0);
        cycle_a(1'b1, 5'd12, 4'hE, 1'b0, 5'd0, 1'b0); model_access(1'b1, 5'd12, 4'hE, 1'b0, 5'd0);
        cycle_a(1'b0, 5'd0, 4'h0, 1'b1, 5'd12, 1'b0); model_access(1'b0, 5'd0, 4'h0, 1'b1, 5'd12);
        cycle_a(1'b1, 5'd3, 4'hF, 1'b1, 5'd3, 1'b1);
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.q_valid !== 1'b0 || bus_b.q_valid !== 1'b0 ||
            bus_a.q !== 4'hE || bus_b.q !== 4'hE) begin
            errors++;
            $display("FAIL clear_start: busy=%b valid=%b/%b q=%h/%h, required busy=1 valid=0 q=E held",
                     bus_a.busy, bus_a.q_valid, bus_b.q_valid, bus_a.q, bus_b.q);
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(1, 15)),
                    1'b1, 5'($urandom_range(0, 31)), 1'b0);
            n++;
            checks++;
            if (bus_a.q_valid !== 1'b0 || bus_b.q_valid !== 1'b0 || bus_a.q !== 4'hE || bus_b.q !== 4'hE) begin
                errors++;
                $display("FAIL clear_locked[%0d]: valid=%b/%b q=%h/%h, required valid=0 q=E",
                         i, bus_a.q_valid, bus_b.q_valid, bus_a.q, bus_b.q);
            end
            if (!bus_a.busy) break;
        end
        checks++;
        if (n != 32 || bus_b.busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy_len: busy low after %0d edges, required 32", n);
        end
        model_zero();
        for (int i = 0; i < 32; i++) begin
            cycle_a(1'b0, 5'd0, 4'h0, 1'b1, 5'(i), 1'b0);
            model_access(1'b0, 5'd0, 4'h0, 1'b1, 5'(i));
            checks++;
            if (bus_a.q !== exp_q0 || bus_b.q !== exp_q1 || bus_a.q_valid !== 1'b1) begin
                errors++;
                $display("FAIL clear_readback[%0d]: q=%h/%h valid=%b, required 0 valid=1",
                         i, bus_a.q, bus_b.q, bus_a.q_valid);
            end
        end
        $display("clear: busy for %0d edges, memory zeroed", n);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        cycle_a(1'b1, 5'd4, 4'h6, 1'b0, 5'd0, 1'b0); model_access(1'b1, 5'd4, 4'h6, 1'b0, 5'd0);
        cycle_a(1'b0, 5'd0, 4'h0, 1'b1, 5'd4, 1'b0); model_access(1'b0, 5'd0, 4'h0, 1'b1, 5'd4);
        cycle_a(1'b0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 10; i++) cycle_a(1'b0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b0);
        checks++;
        if (bus_a.q !== 4'h6 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL midclear_pre: q=%h busy=%b, required 6 busy=1", bus_a.q, bus_a.busy);
        end
        resetn = 1'b0;
        #2;
        checks++;
        if (bus_a.q !== 4'h0 || bus_b.q !== 4'h0 || bus_a.q_valid !== 1'b0 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL midclear_async_reset: q=%h/%h valid=%b busy=%b, required q=0 valid=0 busy=1",
                     bus_a.q, bus_b.q, bus_a.q_valid, bus_a.busy);
        end
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            n++;
            if (!bus_a.busy) break;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL midclear_busy_len: busy low after %0d edges, required 32", n);
        end
        model_zero();
        exp_q0 = 4'h0; exp_q1 = 4'h0;
        cycle_a(1'b0, 5'd0, 4'h0, 1'b1, 5'd4, 1'b0); model_access(1'b0, 5'd0, 4'h0, 1'b1, 5'd4);
        checks++;
        if (bus_a.q !== exp_q0 || bus_b.q !== exp_q1 || bus_a.q_valid !== 1'b1) begin
            errors++;
            $display("FAIL midclear_readback: q=%h/%h valid=%b, required 0 valid=1", bus_a.q, bus_b.q, bus_a.q_valid);
        end
        cycle_a(1'b0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b0);
        $display("reset_mid_clear: busy for %0d edges after release", n);
    endtask

    task automatic test_small_config();
        int n;
        checks++;
        if (bus_c.busy !== 1'b1 || bus_c.q !== 8'h00 || bus_c.q_valid !== 1'b0) begin
            errors++;
            $display("FAIL small_reset: busy=%b q=%h valid=%b, required busy=1 q=00 valid=0",
                     bus_c.busy, bus_c.q, bus_c.q_valid);
        end
        resetn_c = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            n++;
            if (!bus_c.busy) break;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL small_busy_len: busy low after %0d edges, required 8", n);
        end
        cycle_c(1'b1, 3'd7, 8'hC5, 1'b0, 3'd0);
        cycle_c(1'b1, 3'd0, 8'h5C, 1'b0, 3'd0);
        cycle_c(1'b0, 3'd0, 8'h00, 1'b1, 3'd7);
        checks++;
        if (bus_c.q !== 8'hC5 || bus_c.q_valid !== 1'b1) begin
            errors++;
            $display("FAIL small_read7: q=%h valid=%b, required C5 valid=1", bus_c.q, bus_c.q_valid);
        end
        cycle_c(1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
        checks++;
        if (bus_c.q !== 8'h5C) begin
            errors++;
            $display("FAIL small_read0: q=%h, required 5C", bus_c.q);
        end
        cycle_c(1'b1, 3'd2, 8'h11, 1'b1, 3'd7);
        checks++;
        if (bus_c.q !== 8'hC5 || bus_c.q_valid !== 1'b1) begin
            errors++;
            $display("FAIL small_indep: q=%h valid=%b, required C5 valid=1", bus_c.q, bus_c.q_valid);
        end
        cycle_c(1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
        checks++;
        if (bus_c.q !== 8'h11) begin
            errors++;
            $display("FAIL small_read2: q=%h, required 11", bus_c.q);
        end
        cycle_c(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        $display("small_config: busy %0d edges, reads done", n);
    endtask

    initial begin
        bus_a.wren = 1'b0; bus_a.wraddr = '0; bus_a.data = '0;
        bus_a.rden = 1'b0; bus_a.rdaddr = '0; bus_a.clr = 1'b0;
        bus_c.wren = 1'b0; bus_c.wraddr = '0; bus_c.data = '0;
        bus_c.rden = 1'b0; bus_c.rdaddr = '0; bus_c.clr = 1'b0;
        test_reset();
        test_defaults();
        test_write_read();
        test_rdw();
        test_random();
        test_clear();
        test_reset_mid_clear();
        test_small_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised simple dual-port RAM: one write port and one independent read port.
- Successor to the lab 32x4 single-port RAM, which had a combinational read and undefined power-up contents.
- Adds a registered read with a valid strobe, a selectable read-during-write policy, and a hardware clear engine that zeroes every location after reset or on request.
- Sits between switch/key input logic and hex_ssd display drivers; also usable as a generic scratch memory in later labs.

Parameters:
- DATA_W, 4: word width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0: same-address read during write. 0 = old data (read-first), 1 = new data (write-first bypass).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wren  in  1  write enable.
- wraddr  in  ADDR_W  write address.
- data  in  DATA_W  write data.
- rden  in  1  read enable.
- rdaddr  in  ADDR_W  read address.
- clr  in  1  synchronous request to zero the whole memory.
- q  out  DATA_W  registered read data.
- q_valid  out  1  one-cycle strobe: q updated this cycle.
- busy  out  1  high while the clear engine runs; the ports are locked.

Behaviour:
- Reset (resetn=0, asynchronous):
  - q=0, q_valid=0, busy=1.
  - FSM enters CLEAR with clear counter cnt=0.
  - The array itself has no reset; it is zeroed by CLEAR.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each rising edge writes 0 to mem[cnt], then cnt increments.
  - The edge that writes mem[DEPTH-1] moves the FSM to IDLE and drops busy.
  - After resetn rises, busy stays high for exactly DEPTH rising edges, so all DEPTH locations are written.
  - wren and rden are ignored; q holds, q_valid=0.
  - clr asserted in CLEAR restarts cnt at 0 next edge; busy stays high.
- IDLE:
  - busy=0.
  - wren=1: mem[wraddr] <= data on the edge.
  - rden=1: on the edge q <= mem[rdaddr] and q_valid <= 1; read latency is 1 cycle.
  - rden=0: q holds its last value, q_valid <= 0.
  - clr=1: transition to CLEAR on the edge with cnt=0; busy=1 from the next cycle. A wren or rden in the same cycle is dropped (clr wins), so q_valid <= 0.
- Read during write, same address (wren=rden=1, wraddr==rdaddr):
  - RDW_MODE=0: q gets the pre-write contents.
  - RDW_MODE=1: q gets data.
  - The memory is written in both modes.
- Different addresses: read and write are fully independent in the same cycle.
- Addresses are exactly ADDR_W bits, so no out-of-range access exists. cnt is ADDR_W bits and wraps to 0 after DEPTH-1; the wrap edge ends CLEAR.
- Reset asserted mid-CLEAR or mid-IDLE: immediate return to the reset values; the clear restarts from address 0 after release.
- Widths: data/q are DATA_W with no extension or truncation. cnt is ADDR_W bits with an explicit terminal compare to DEPTH-1.
- No X may propagate to q after the first completed CLEAR.

Test Plan:
1. Defaults. Release resetn and count edges: busy=1 for exactly 32 edges, then 0. Read all 32 addresses: every q=0, with q_valid pulsing one cycle after each rden.
2. Write 0xA to addr 5, 0x3 to addr 31, then rden addr 5, then addr 31: q=0xA one edge after the first rden and q=0x3 after the second, q_valid=1 each time. q holds when rden=0.
3. RDW, addr 7 preloaded with 0x2, then wren=rden=1 at addr 7 with data=0x9:
   - RDW_MODE=0 gives q=0x2.
   - RDW_MODE=1 gives q=0x9.
   - A following read returns 0x9 in both modes.
4. Clear: fill several addresses with nonzero data, then pulse clr for one cycle together with wren (addr 3, 0xF):
   - busy high for 32 edges.
   - wren/rden ignored during clear.
   - Afterwards all addresses read 0, including addr 3.
5. Reset mid-clear: assert resetn=0 at clear edge 10. q and q_valid go 0 immediately (asynchronously), busy=1. After release, busy lasts the full 32 edges.
6. Parametrised instance DATA_W=8, ADDR_W=3:
   - busy lasts 8 edges.
   - Write 0xC5 to addr 7 and 0x5C to addr 0; read back both.
   - Simultaneous write addr 2 with read addr 7 returns 0xC5.
